// File: rtl/sipo_rx.sv
// sipo_rx: serial-to-parallel receiver with sync-framed words, overrun flag and optional parity check (SIPO_RX_PARITY_CHECK_EN)
module sipo_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sin,
  input  logic             sen,
  input  logic             sync,
  input  logic             rd,
  output logic [WIDTH-1:0] pout,
  output logic             pvalid,
  output logic             busy,
  output logic             ovr,
  output logic             perr
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic done;
`ifdef SIPO_RX_PARITY_CHECK_EN
  logic par_n;
`endif
  assign busy = state != IDLE;
  // Framing FSM state, bit count and shift register
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
    end
  // Next state; sync always restarts a word, so the MSB lands in bit 0 and shifts up
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    done = 1'b0;
`ifdef SIPO_RX_PARITY_CHECK_EN
    par_n = 1'b0;
`endif
    if (sen) begin
      if (sync) begin
        state_n = SHIFT;
        cnt_n = CW'(1);
        sh_n = {{(WIDTH-1){1'b0}}, sin};
      end else if (state == SHIFT) begin
        sh_n = {sh[WIDTH-2:0], sin};
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          cnt_n = '0;
`ifdef SIPO_RX_PARITY_CHECK_EN
          state_n = PAR;
`else
          state_n = IDLE;
          done = 1'b1;
`endif
        end
      end
`ifdef SIPO_RX_PARITY_CHECK_EN
      else if (state == PAR) begin
        state_n = IDLE;
        done = 1'b1;
        par_n = ^{sh, sin};
      end
`endif
    end
  end
  // Output word register: a completed word is dropped (and ovr set) only if the previous one is still unread
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      pout <= '0;
      pvalid <= 1'b0;
      ovr <= 1'b0;
    end else if (done && pvalid && !rd) ovr <= 1'b1;
    else if (done) begin
      pout <= sh_n;
      pvalid <= 1'b1;
    end else if (rd) pvalid <= 1'b0;
`ifdef SIPO_RX_PARITY_CHECK_EN
  // Parity result travels with the word it belongs to
  always_ff @(posedge clk or posedge clr)
    if (clr) perr <= 1'b0;
    else if (done && (!pvalid || rd)) perr <= par_n;
`else
  assign perr = 1'b0;
`endif
endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: directed checks of sipo_rx framing, overrun, read handshake, reset and parity
module tb_sipo_rx;
`ifdef SIPO_RX_PARITY_CHECK_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif
  logic clk = 1'b0, clr = 1'b1, sin = 1'b0, sen = 1'b0, sync = 1'b0, rd = 1'b0;
  logic [3:0] pout;
  logic pvalid, busy, ovr, perr;
  int n_chk = 0, n_fail = 0;

  sipo_rx #(.WIDTH(4)) dut (
    .clk(clk), .clr(clr), .sin(sin), .sen(sen), .sync(sync), .rd(rd),
    .pout(pout), .pvalid(pvalid), .busy(busy), .ovr(ovr), .perr(perr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bit_in(input logic s, input logic sy, input logic e, input logic r);
    sin = s;
    sync = sy;
    sen = e;
    rd = r;
    @(posedge clk);
    #1;
    sen = 1'b0;
    sync = 1'b0;
    rd = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w, input logic flip, input logic rd_last, input logic gap);
    for (int i = 3; i >= 0; i--) begin
      bit_in(w[i], i == 3, 1'b1, (i == 0) && !PE && rd_last);
      if (gap && i == 3) bit_in(1'b0, 1'b0, 1'b0, 1'b0);
    end
    if (PE) bit_in(^w ^ flip, 1'b0, 1'b1, rd_last);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pout"}, pout, 0);
    chk({tag, "_pvalid"}, pvalid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovr"}, ovr, 0);
    chk({tag, "_perr"}, perr, 0);
  endtask

  initial begin
    #12;
    check_all_zero("reset");
    clr = 1'b0;
    @(posedge clk);
    #1;
    sin = 1'b1; sync = 1'b1; sen = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_after_sync", busy, 1);
    sync = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      sin = i[0] | (i == 0);
      @(posedge clk);
      #1;
      if (i > 0) chk("no_pvalid_mid_word", pvalid, 0);
    end
    sen = 1'b0;
    if (PE) bit_in(1'b1, 1'b0, 1'b1, 1'b0);
    chk("w1_pout", pout, 4'b1011);
    chk("w1_pvalid", pvalid, 1);
    chk("w1_busy", busy, 0);
    chk("w1_perr", perr, 0);
    send_word(4'b0110, 1'b0, 1'b0, 1'b0);
    chk("ovr_pout_kept", pout, 4'b1011);
    chk("ovr_set", ovr, 1);
    chk("ovr_pvalid", pvalid, 1);
    bit_in(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rd_clears_pvalid", pvalid, 0);
    chk("ovr_sticky", ovr, 1);
    bit_in(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rd_idle_pvalid", pvalid, 0);
    chk("rd_idle_pout", pout, 4'b1011);
    clr = 1'b1;
    #3;
    clr = 1'b0;
    chk("clr_ovr", ovr, 0);
    bit_in(1'b1, 1'b0, 1'b1, 1'b0);
    bit_in(1'b1, 1'b0, 1'b1, 1'b0);
    chk("nosync_busy", busy, 0);
    send_word(4'b0010, 1'b0, 1'b0, 1'b0);
    chk("w3_pout", pout, 4'b0010);
    chk("w3_pvalid", pvalid, 1);
    chk("w3_ovr", ovr, 0);
    bit_in(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(4'b1011, 1'b0, 1'b0, 1'b0);
    send_word(4'b1001, 1'b0, 1'b1, 1'b0);
    chk("same_cycle_pout", pout, 4'b1001);
    chk("same_cycle_pvalid", pvalid, 1);
    chk("same_cycle_ovr", ovr, 0);
    bit_in(1'b0, 1'b0, 1'b0, 1'b1);
    bit_in(1'b1, 1'b1, 1'b1, 1'b0);
    bit_in(1'b1, 1'b0, 1'b1, 1'b0);
    chk("restart_busy", busy, 1);
    send_word(4'b0101, 1'b0, 1'b0, 1'b1);
    chk("restart_pout", pout, 4'b0101);
    chk("restart_pvalid", pvalid, 1);
    bit_in(1'b1, 1'b1, 1'b1, 1'b0);
    bit_in(1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    clr = 1'b1;
    #1;
    check_all_zero("async_clr");
    @(posedge clk);
    #2;
    clr = 1'b0;
    @(posedge clk);
    #1;
    bit_in(1'b1, 1'b0, 1'b1, 1'b0);
    bit_in(1'b0, 1'b0, 1'b1, 1'b0);
    chk("post_clr_pvalid", pvalid, 0);
    chk("post_clr_busy", busy, 0);
    for (int i = 0; i < 4; i++) bit_in(i < 2, 1'b0, 1'b1, 1'b0);
    chk("post_clr_nosync_pvalid", pvalid, 0);
    send_word(4'b1100, 1'b0, 1'b0, 1'b0);
    chk("post_clr_pout", pout, 4'b1100);
    chk("post_clr_pvalid_sync", pvalid, 1);
    bit_in(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(4'b1011, 1'b1, 1'b0, 1'b0);
    chk("par_bad_pout", pout, 4'b1011);
    chk("par_bad_perr", perr, PE);
    bit_in(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(4'b1011, 1'b0, 1'b0, 1'b0);
    chk("par_good_perr", perr, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
